// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and mode constants for the SPI frame transmitter
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP,
    S_DONE
  } statetype;

  // Mode 0: CPOL=0, CPHA=0 (data sampled on the rising sclk edge).
  localparam int SPI_MODE = 0;

  // Level sclk rests at between toggles, derived from the mode's CPOL bit.
  localparam logic SCLK_IDLE = (SPI_MODE >= 2);

endpackage

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - SPI half-period divider producing one tick every CLK_DIV clocks
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Free-running 0..CLK_DIV-1 counter; clr restarts the half-period on state changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_frame_tx.sv
// rtl/spi_frame_tx.sv - SPI mode-0 frame initiator, one WORD_W word per start; optional receive path under SPI_FRAME_TX_MISO_EN
module spi_frame_tx
  import spi_pkg::*;
#(
  parameter int WORD_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              cs,
  output logic              sclk,
  output logic              mosi
`ifdef SPI_FRAME_TX_MISO_EN
  ,
  input  logic              miso,
  output logic [WORD_W-1:0] rx_data
`endif
);

  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  statetype          state;
  statetype          state_next;
  logic              tick;
  logic              clr;
  logic [WORD_W-1:0] shreg;
  logic [BW-1:0]     bitcnt;
  logic              sclk_q;

  // Each state owns whole half-periods, so the divider restarts whenever the state moves.
  assign clr = (state_next != state);

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  // State register; an asserted reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: each framing phase lasts one half-period, the shift phase 2*WORD_W of them.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_SETUP;
      S_SETUP: if (tick) state_next = S_SHIFT;
      S_SHIFT: if (tick && sclk_q && (bitcnt == '0)) state_next = S_HOLD;
      S_HOLD:  if (tick) state_next = S_GAP;
      S_GAP:   if (tick) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Transmit datapath: latch on accept, toggle sclk per tick, advance the word on falling toggles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg  <= '0;
      bitcnt <= '0;
      sclk_q <= SCLK_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shreg  <= data_in;
            bitcnt <= BW'(WORD_W - 1);
          end
        end
        S_SHIFT: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            if (sclk_q && (bitcnt != '0)) begin
              shreg  <= shreg << 1;
              bitcnt <= bitcnt - BW'(1);
            end
          end
        end
        default: sclk_q <= SCLK_IDLE;
      endcase
    end
  end

`ifdef SPI_FRAME_TX_MISO_EN
  logic [WORD_W-1:0] rx_shreg;

  // Receive path: sample miso on rising toggles, publish the word as the frame enters S_DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_shreg <= '0;
      rx_data  <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        rx_shreg <= '0;
      end else if (state == S_SHIFT && tick && !sclk_q) begin
        rx_shreg <= (rx_shreg << 1) | WORD_W'(miso);
      end
      if (state == S_GAP && tick) begin
        rx_data <= rx_shreg;
      end
    end
  end
`endif

  // Outputs decoded from state: cs covers setup, shift and hold; mosi is quiet outside the frame.
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
    cs   = (state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD);
    sclk = sclk_q;
    mosi = cs ? shreg[WORD_W-1] : 1'b0;
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// tb/tb_spi_frame_tx.sv - self-checking bench for spi_frame_tx (16-bit/div-2 and 1-bit/div-1 instances)
module tb_spi_frame_tx;

  localparam int W        = 16;
  localparam int D        = 2;
  localparam int BUSY_EXP = D * (2 * W + 3) + 1;
  localparam int CS_EXP   = D * (2 * W + 2);
  localparam int GAP_EXP  = D + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         busy, done, cs, sclk, mosi;

  logic         s_start = 1'b0;
  logic [0:0]   s_data = 1'b0;
  logic         s_busy, s_done, s_cs, s_sclk, s_mosi;

`ifdef SPI_FRAME_TX_MISO_EN
  logic         miso = 1'b0;
  logic [W-1:0] rx_data;
  logic         s_miso = 1'b0;
  logic [0:0]   s_rx;
`endif

  int tests = 0;
  int fails = 0;

  spi_frame_tx #(.WORD_W(W), .CLK_DIV(D)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .start   (start),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .cs      (cs),
    .sclk    (sclk),
    .mosi    (mosi)
`ifdef SPI_FRAME_TX_MISO_EN
    ,
    .miso    (miso),
    .rx_data (rx_data)
`endif
  );

  spi_frame_tx #(.WORD_W(1), .CLK_DIV(1)) dut_small (
    .clk     (clk),
    .reset   (rst_n),
    .start   (s_start),
    .data_in (s_data),
    .busy    (s_busy),
    .done    (s_done),
    .cs      (s_cs),
    .sclk    (s_sclk),
    .mosi    (s_mosi)
`ifdef SPI_FRAME_TX_MISO_EN
    ,
    .miso    (s_miso),
    .rx_data (s_rx)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Receiver model: what a mode-0 slave sees on the wire, plus frame timing measurements.
  typedef struct {
    logic [W-1:0] word;
    int           edges;
    int           busy_c;
    int           cs_c;
  } frame_t;

  frame_t       frames[$];
  logic [W-1:0] m_word = '0;
  int           m_edges = 0, m_busy = 0, m_cs = 0, done_cnt = 0, gap_c = 0, last_gap = 0;
  bit           m_prev_sclk = 0, m_prev_cs = 0, in_gap = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_word = '0; m_edges = 0; m_busy = 0; m_cs = 0;
      m_prev_sclk = 0; m_prev_cs = 0; in_gap = 0; gap_c = 0;
    end else begin
      if (sclk && !m_prev_sclk) begin
        m_word = {m_word[W-2:0], mosi};
        m_edges++;
      end
      m_prev_sclk = sclk;
      if (busy) m_busy++;
      if (cs) m_cs++;
      if (cs && !m_prev_cs && in_gap) begin
        last_gap = gap_c;
        in_gap = 0;
      end
      if (!cs && m_prev_cs) begin
        in_gap = 1;
        gap_c = 0;
      end
      if (!cs && in_gap) gap_c++;
      m_prev_cs = cs;
      if (done) begin
        frames.push_back('{m_word, m_edges, m_busy, m_cs});
        done_cnt++;
        m_word = '0; m_edges = 0; m_busy = 0; m_cs = 0;
      end
    end
  end

  int   s_edges = 0, s_busy_c = 0, s_done_c = 0;
  logic s_mosi_rise = 1'b0;
  bit   s_prev = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      s_edges = 0; s_busy_c = 0; s_done_c = 0; s_mosi_rise = 1'b0; s_prev = 0;
    end else begin
      if (s_sclk && !s_prev) begin
        s_edges++;
        s_mosi_rise = s_mosi;
      end
      s_prev = s_sclk;
      if (s_busy) s_busy_c++;
      if (s_done) s_done_c++;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic send(input logic [W-1:0] w);
    wait_idle();
    data_in = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  task automatic chk_frame(input string tag, input int idx, input logic [W-1:0] exp_word);
    if (idx >= frames.size()) begin
      chk({tag, "_missing"}, frames.size(), idx + 1);
    end else begin
      chk({tag, "_word"},  frames[idx].word,   exp_word);
      chk({tag, "_edges"}, frames[idx].edges,  W);
      chk({tag, "_busy"},  frames[idx].busy_c, BUSY_EXP);
      chk({tag, "_cs"},    frames[idx].cs_c,   CS_EXP);
    end
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] exp_word;
    int           exp_edges;
    int           exp_busy;
    int           exp_cs;
  } vec_t;

  vec_t         vecs[6];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] w;
  logic [W-1:0] pat;
  int           base, k, n;
  bit           pv;

  initial begin
    vecs[0] = '{16'hA55A, 16'hA55A, W, BUSY_EXP, CS_EXP};
    vecs[1] = '{16'h0001, 16'h0001, W, BUSY_EXP, CS_EXP};
    vecs[2] = '{16'h8000, 16'h8000, W, BUSY_EXP, CS_EXP};
    vecs[3] = '{16'hFFFF, 16'hFFFF, W, BUSY_EXP, CS_EXP};
    vecs[4] = '{16'h0000, 16'h0000, W, BUSY_EXP, CS_EXP};
    vecs[5] = '{16'h1234, 16'h1234, W, BUSY_EXP, CS_EXP};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cs",   cs,   0);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table of single frames
    for (int i = 0; i < 6; i++) begin
      frames.delete();
      base = done_cnt;
      send(vecs[i].word);
      wait_done(base + 1);
      if (frames.size() != 1) begin
        chk("vec_frames", frames.size(), 1);
      end else begin
        chk("vec_word",  frames[0].word,   vecs[i].exp_word);
        chk("vec_edges", frames[0].edges,  vecs[i].exp_edges);
        chk("vec_busy",  frames[0].busy_c, vecs[i].exp_busy);
        chk("vec_cs",    frames[0].cs_c,   vecs[i].exp_cs);
      end
    end
    repeat (5) @(negedge clk);
    chk("vec_done_pulses", done_cnt, 6);

    // Back-to-back with start held high; data_in switched after first acceptance
    frames.delete();
    base = done_cnt;
    last_gap = 0;
    wait_idle();
    data_in = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    data_in = 16'h8000;
    wait_done(base + 1);
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    while (!busy && n < 100) begin @(negedge clk); n++; end
    start = 1'b0;
    wait_done(base + 2);
    repeat (20) @(negedge clk);
    chk("b2b_done_pulses", done_cnt - base, 2);
    chk_frame("b2b_f0", 0, 16'h0001);
    chk_frame("b2b_f1", 1, 16'h8000);
    chk("b2b_gap", last_gap, GAP_EXP);

    // Start pulsed mid-shift is ignored
    frames.delete();
    base = done_cnt;
    send(16'h1234);
    n = 0;
    while (m_edges < 3 && n < 200) begin @(negedge clk); n++; end
    data_in = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(base + 1);
    repeat (100) @(negedge clk);
    chk("ign_done_pulses", done_cnt - base, 1);
    chk("ign_frames", frames.size(), 1);
    chk_frame("ign", 0, 16'h1234);

    // Reset at the 8th rising sclk aborts the frame asynchronously
    frames.delete();
    base = done_cnt;
    send(16'hFFFF);
    k = 0; pv = 0; n = 0;
    while (k < 8 && n < 500) begin
      @(negedge clk);
      if (sclk && !pv) k++;
      pv = sclk;
      n++;
    end
    chk("abort_reached_edge8", k, 8);
    chk("abort_pre_cs", cs, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_cs",   cs,   0);
    chk("abort_sclk", sclk, 0);
    chk("abort_mosi", mosi, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt - base, 0);
    send(16'h00F0);
    wait_done(base + 1);
    chk("abort_frames", frames.size(), 1);
    chk_frame("abort_after", 0, 16'h00F0);

    // WORD_W=1, CLK_DIV=1 instance
    s_data = 1'b1;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    while (s_done_c < 1 && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("w1_edges",     s_edges,     1);
    chk("w1_mosi_rise", s_mosi_rise, 1);
    chk("w1_busy",      s_busy_c,    6);
    chk("w1_done",      s_done_c,    1);
    chk("w1_cs_idle",   s_cs,        0);

    // Randomized frames against the queue model
    frames.delete();
    exp_q.delete();
    base = done_cnt;
    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom);
      exp_q.push_back(w);
      send(w);
      wait_done(base + i + 1);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    chk("rand_count", frames.size(), exp_q.size());
    for (int i = 0; i < 20 && i < frames.size(); i++) begin
      chk("rand_word", frames[i].word,   exp_q[i]);
      chk("rand_busy", frames[i].busy_c, BUSY_EXP);
    end

`ifdef SPI_FRAME_TX_MISO_EN
    // Receive path: slave model returns 16'hC3C3 while 16'h1111 goes out
    frames.delete();
    base = done_cnt;
    wait_idle();
    pat = 16'hC3C3;
    k = 0; pv = 0;
    miso = pat[W-1];
    data_in = 16'h1111;
    start = 1'b1;
    for (int i = 0; i < 400 && done_cnt < base + 1; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (sclk && !pv) k++;
      pv = sclk;
      miso = (k < W) ? pat[W-1-k] : 1'b0;
    end
    chk("miso_rx_data", rx_data, 16'hC3C3);
    chk_frame("miso_tx", 0, 16'h1111);
    miso = 1'b0;
    send(16'h2222);
    n = 0;
    while (m_edges < 10 && n < 200) begin @(negedge clk); n++; end
    chk("miso_rx_hold", rx_data, 16'hC3C3);
    wait_done(base + 2);
    @(negedge clk);
    chk("miso_rx_next", rx_data, 16'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
